register_bank: RTL

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank.sv | 118 +++++++++++
 1 files changed

// File: rtl/register_bank.sv
// Register bank with IR, general registers, carry/zero flags and a small output FIFO.
// Loads land one edge after their strobe; the queue drops pushes only when full with no pop.

// Generic valid/ready FIFO; head visible the cycle after the push edge.
// in_rdy stays high when full if the head is popped on the same edge.
module reg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_vld,
    input  logic [WIDTH-1:0]           in_dat,
    output logic                       in_rdy,
    output logic                       out_vld,
    output logic [WIDTH-1:0]           out_dat,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    assign out_vld = (cnt != '0);
    assign out_dat = out_vld ? mem[rd_ptr] : '0;
    assign pop     = out_vld && out_rdy;
    assign in_rdy  = (cnt != FULL) || pop;
    assign push    = in_vld && in_rdy;
    assign count   = cnt;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_dat;
    end
endmodule

// Top level: IR (self-clearing), NREGS registers, flags, output queue.
// All state updates one edge after the strobe; q_overflow is sticky until reset.
module register_bank #(
    parameter int WIDTH     = 8,
    parameter int NREGS     = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               dbus,
    input  logic                           load_ir,
    input  logic [NREGS-1:0]               load_en,
    input  logic                           flag_en,
    input  logic                           carry,
    input  logic                           out_en,
    input  logic                           q_ready,
    output logic [WIDTH-1:0]               ir,
    output logic [NREGS*WIDTH-1:0]         regs,
    output logic                           flag_carry,
    output logic                           flag_zero,
    output logic [WIDTH-1:0]               q_data,
    output logic                           q_valid,
    output logic [$clog2(OUT_DEPTH+1)-1:0] q_count,
    output logic                           q_overflow
);
    logic push_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            ir         <= '0;
            regs       <= '0;
            flag_carry <= 1'b0;
            flag_zero  <= 1'b0;
            q_overflow <= 1'b0;
        end else begin
            ir <= load_ir ? dbus : '0;
            for (int i = 0; i < NREGS; i++) begin
                if (load_en[i]) regs[i*WIDTH +: WIDTH] <= dbus;
            end
            if (flag_en) begin
                flag_carry <= carry;
                flag_zero  <= (dbus == '0);
            end
            if (out_en && !push_rdy) q_overflow <= 1'b1;
        end
    end

    reg_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_q (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (out_en),
        .in_dat  (dbus),
        .in_rdy  (push_rdy),
        .out_vld (q_valid),
        .out_dat (q_data),
        .out_rdy (q_ready),
        .count   (q_count)
    );
endmodule
